// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
// Holds the FSM state encoding and the saturating-increment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam int unsigned ADDR_W_DEF    = 32;
  localparam int unsigned INSTR_W_DEF   = 32;
  localparam int unsigned ROM_DEPTH_DEF = 1024;
  localparam logic [31:0] RESET_PC      = 32'd0;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating handshake / stall counters for the fetch sequencer.
// Only instantiated when FETCH_PERF_EN is defined.
module fetch_perf_cnt
  import fetch_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  logic [31:0] fetch_cnt_r;
  logic [31:0] stall_cnt_r;

  // Accepted-handshake counter; clear wins over increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_r <= 32'd0;
    end else if (clear) begin
      fetch_cnt_r <= 32'd0;
    end else if (fetch_inc) begin
      fetch_cnt_r <= sat_inc32(fetch_cnt_r);
    end else begin
      fetch_cnt_r <= fetch_cnt_r;
    end
  end

  // Stall-cycle counter; clear wins over increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_r <= 32'd0;
    end else if (clear) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_inc) begin
      stall_cnt_r <= sat_inc32(stall_cnt_r);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_r;
  assign perf_stall_cnt = stall_cnt_r;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses a 1-cycle sync ROM, feeds decode via valid/ready.
// Optional macro FETCH_PERF_EN adds saturating handshake/stall performance counters.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned INSTR_W   = INSTR_W_DEF,
  parameter int unsigned ROM_DEPTH = ROM_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC_P = ADDR_W'(RESET_PC)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               halt_req,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W:0]   rom_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               running,
`ifdef FETCH_PERF_EN
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt,
`endif
  output logic               fetch_err
);

  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(ROM_DEPTH);

  fetch_state_e      state_r;
  fetch_state_e      state_nxt_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_d_s;
  logic [ADDR_W-1:0] pc_nxt_s;
  logic              vld_r;
  logic              vld_nxt_s;
  logic              err_r;
  logic              err_nxt_s;
  logic              out_valid_s;
  logic              hs_s;
  logic              range_err_s;
  logic              unused_rom_msb_s;

  assign out_valid_s      = vld_r & (state_r == RUN);
  assign hs_s             = out_valid_s & out_ready;
  assign unused_rom_msb_s = rom_instr[INSTR_W];

  // Next-PC mux; an out-of-range target leaves the PC where it is.
  always_comb begin
    pc_d_s   = pc_r;
    pc_nxt_s = pc_r;
    if (redirect_valid) begin
      pc_d_s = redirect_pc;
    end else if (hs_s) begin
      pc_d_s = pc_r + PC_ONE;
    end else begin
      pc_d_s = pc_r;
    end
    range_err_s = ({1'b0, pc_d_s} >= DEPTH_L);
    if (range_err_s) begin
      pc_nxt_s = pc_r;
    end else begin
      pc_nxt_s = pc_d_s;
    end
  end

  // FSM next state, valid and sticky error; halt beats start.
  always_comb begin
    state_nxt_s = state_r;
    err_nxt_s   = err_r;
    case (state_r)
      IDLE, HALT: begin
        if (!range_err_s && start && !halt_req) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      RUN: begin
        if (halt_req || range_err_s) begin
          state_nxt_s = HALT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    if (range_err_s) begin
      err_nxt_s = 1'b1;
    end else if (start) begin
      err_nxt_s = 1'b0;
    end else begin
      err_nxt_s = err_r;
    end
    vld_nxt_s = (state_nxt_s == RUN) && !range_err_s;
  end

  // State, PC, valid and error registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC_P;
      vld_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      vld_r   <= vld_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign rom_addr  = pc_nxt_s;
  assign out_valid = out_valid_s;
  assign out_instr = rom_instr[INSTR_W-1:0];
  assign out_pc    = pc_r;
  assign running   = (state_r == RUN);
  assign fetch_err = err_r;

`ifdef FETCH_PERF_EN
  logic perf_clr_s;

  assign perf_clr_s = (state_r == IDLE) && (state_nxt_s == RUN);

  fetch_perf_cnt u_perf (
    .clock          (clock),
    .reset_n        (reset_n),
    .clear          (perf_clr_s),
    .fetch_inc      (hs_s),
    .stall_inc      (out_valid_s & ~out_ready),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Table-driven bench for instr_fetch_ctrl with a behavioural 1-cycle ROM.
// Honors FETCH_PERF_EN to also check the performance counters.
module tb_instr_fetch_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int NV = 21;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        halt_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] rom_addr;
  logic [32:0] rom_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        running;
  logic        fetch_err;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_fetch = 0;
  int exp_stall = 0;

  typedef struct packed {
    logic        st;
    logic        hr;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic        erun;
    logic        eerr;
  } vec_t;

  vec_t vecs [0:NV-1];

  instr_fetch_ctrl #(.ADDR_W(32), .INSTR_W(32), .ROM_DEPTH(DEPTH), .RESET_PC_P(32'd0)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .running        (running),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .fetch_err      (fetch_err)
  );

  function automatic logic [32:0] rom_fn(input logic [31:0] a);
    return {a[0], 32'hA500_0000 + a * 32'h0000_0101};
  endfunction

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) rom_instr <= rom_fn(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic hr, input logic rv, input logic [31:0] rpc, input logic rdy);
    start = st; halt_req = hr; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
  endtask

  initial begin
    // st hr rv rpc rdy | ev epc run err
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 32'd0,  1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd0,  1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd1,  1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd2,  1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd3,  1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b0, 32'd0,  1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 32'd0,  1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'd9,  1'b1, 1'b1, 32'd4,  1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd9,  1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 32'd10, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 32'd10, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 32'd10, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd10, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 32'd14, 1'b0, 1'b1, 32'd11, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd14, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd15, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 32'd0,  1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 32'd2,  1'b0, 1'b0, 32'd0,  1'b0, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0,  1'b0, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd2,  1'b1, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 32'd3,  1'b1, 1'b0};

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset running", {31'd0, running}, 32'd0);
    check("reset fetch_err", {31'd0, fetch_err}, 32'd0);
    check("reset out_pc", out_pc, 32'd0);
    check("reset rom_addr", rom_addr, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      drive(vecs[i].st, vecs[i].hr, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      #1;
      check($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
      check($sformatf("v%0d running", i), {31'd0, running}, {31'd0, vecs[i].erun});
      check($sformatf("v%0d fetch_err", i), {31'd0, fetch_err}, {31'd0, vecs[i].eerr});
      if (vecs[i].ev) begin
        check($sformatf("v%0d out_pc", i), out_pc, vecs[i].epc);
        check($sformatf("v%0d out_instr", i), out_instr, rom_fn(vecs[i].epc)[31:0]);
        if (vecs[i].rdy) exp_fetch++;
        else exp_stall++;
      end
    end

    // Stall still held after the table; counters reflect everything so far.
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    #1;
    check("held out_valid", {31'd0, out_valid}, 32'd1);
    check("held out_pc", out_pc, 32'd3);
    check("held out_instr", out_instr, rom_fn(32'd3)[31:0]);
`ifdef FETCH_PERF_EN
    check("perf fetch", perf_fetch_cnt, exp_fetch);
    check("perf stall", perf_stall_cnt, exp_stall);
`endif

    // Asynchronous reset in the middle of a stall.
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset running", {31'd0, running}, 32'd0);
    check("midreset out_pc", out_pc, 32'd0);
`ifdef FETCH_PERF_EN
    check("midreset perf fetch", perf_fetch_cnt, 32'd0);
    check("midreset perf stall", perf_stall_cnt, 32'd0);
`endif

    @(negedge clock);
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    #1;
    check("restart idle valid", {31'd0, out_valid}, 32'd0);
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    #1;
    check("restart valid", {31'd0, out_valid}, 32'd1);
    check("restart pc0", out_pc, 32'd0);
    check("restart instr0", out_instr, rom_fn(32'd0)[31:0]);
    @(negedge clock);
    #1;
    check("restart pc1", out_pc, 32'd1);
    check("restart instr1", out_instr, rom_fn(32'd1)[31:0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
